// File: rtl/jtag_scan_sequencer_if.sv
// Command/response handshake between the host/debug logic and jtag_scan_sequencer.
// The host uses the master modport; the sequencer uses the slave modport.
interface jtag_scan_sequencer_if #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_is_ir;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               cmd_tlr;
   logic               rsp_valid;
   logic [MAX_LEN-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_is_ir, cmd_len, cmd_data, cmd_tlr,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_is_ir, cmd_len, cmd_data, cmd_tlr,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// Drives TMS/TDI into a lockstep JTAG TAP for one IR or DR scan per command, shifting
// LSB first, and returns the captured TDO bits as a one-cycle response pulse.
module jtag_scan_sequencer #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                        tclk_i,
   input  logic                        trst_i,
   jtag_scan_sequencer_if.slave        bus_io,
   output logic                        tms_o,
   output logic                        tdi_o,
   input  logic                        tdo_i,
   output logic                        busy_o,
   output logic [3:0]                  tap_state_o
);
   localparam int unsigned      IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);

   localparam logic [3:0] TapTlr   = 4'd0;
   localparam logic [3:0] TapRti   = 4'd1;
   localparam logic [3:0] TapSelDr = 4'd2;
   localparam logic [3:0] TapCapDr = 4'd3;
   localparam logic [3:0] TapShDr  = 4'd4;
   localparam logic [3:0] TapEx1Dr = 4'd5;
   localparam logic [3:0] TapUpdDr = 4'd8;
   localparam logic [3:0] TapSelIr = 4'd9;
   localparam logic [3:0] TapCapIr = 4'd10;
   localparam logic [3:0] TapShIr  = 4'd11;
   localparam logic [3:0] TapEx1Ir = 4'd12;
   localparam logic [3:0] TapUpdIr = 4'd15;

   typedef enum logic [3:0] {
      StRstSeq, StTlr, StIdle, StLaunch, StSelDr, StSelIr, StCapture, StShift, StExit1, StUpdate
   } state_e;

   state_e             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic               is_ir_q, is_ir_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] rx_q, rx_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

   logic [LEN_W-1:0]   cmd_len_eff;
   logic               last_bit;
   logic               tms, tdi, cmd_ready;
   logic [3:0]         tap_state;

   // Zero length behaves as one bit; oversize lengths saturate at MAX_LEN.
   always_comb begin
      if (bus_io.cmd_len == '0) begin
         cmd_len_eff = LEN_W'(1);
      end else if (bus_io.cmd_len > MaxLenL) begin
         cmd_len_eff = MaxLenL;
      end else begin
         cmd_len_eff = bus_io.cmd_len;
      end
   end

   assign last_bit = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      is_ir_d     = is_ir_q;
      len_d       = len_q;
      data_d      = data_q;
      rx_d        = rx_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      tms         = 1'b0;
      tdi         = 1'b0;
      cmd_ready   = 1'b0;
      tap_state   = TapTlr;
      unique case (state_q)
         StRstSeq: begin
            tms = 1'b1;
            if (cnt_q == 3'd4) begin
               state_d = StTlr;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StTlr: state_d = StIdle;
         StIdle: begin
            tap_state = TapRti;
            // A pending reset request holds off the handshake so the command stays queued.
            cmd_ready = !bus_io.cmd_tlr;
            if (bus_io.cmd_tlr) begin
               state_d = StRstSeq;
               cnt_d   = '0;
            end else if (bus_io.cmd_valid) begin
               is_ir_d = bus_io.cmd_is_ir;
               len_d   = cmd_len_eff;
               data_d  = bus_io.cmd_data;
               rx_d    = '0;
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            tms       = 1'b1;
            tap_state = TapRti;
            state_d   = StSelDr;
         end
         StSelDr: begin
            tms       = is_ir_q;
            tap_state = TapSelDr;
            state_d   = is_ir_q ? StSelIr : StCapture;
         end
         StSelIr: begin
            tap_state = TapSelIr;
            state_d   = StCapture;
         end
         StCapture: begin
            tap_state = is_ir_q ? TapCapIr : TapCapDr;
            idx_d     = '0;
            state_d   = StShift;
         end
         StShift: begin
            tap_state  = is_ir_q ? TapShIr : TapShDr;
            tms        = last_bit;
            tdi        = data_q[idx_q];
            rx_d[idx_q] = tdo_i;
            if (last_bit) begin
               state_d = StExit1;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StExit1: begin
            tms       = 1'b1;
            tap_state = is_ir_q ? TapEx1Ir : TapEx1Dr;
            state_d   = StUpdate;
         end
         StUpdate: begin
            tap_state   = is_ir_q ? TapUpdIr : TapUpdDr;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
            state_d     = StIdle;
         end
         default: state_d = StRstSeq;
      endcase
   end

   always_ff @(posedge tclk_i or posedge trst_i) begin
      if (trst_i) begin
         state_q     <= StRstSeq;
         cnt_q       <= '0;
         idx_q       <= '0;
         is_ir_q     <= 1'b0;
         len_q       <= LEN_W'(1);
         data_q      <= '0;
         rx_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         is_ir_q     <= is_ir_d;
         len_q       <= len_d;
         data_q      <= data_d;
         rx_q        <= rx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign tms_o            = tms;
   assign tdi_o            = tdi;
   assign tap_state_o      = tap_state;
   assign busy_o           = (state_q != StIdle);
   assign bus_io.cmd_ready = cmd_ready;
   assign bus_io.rsp_valid = rsp_valid_q;
   assign bus_io.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer against a behavioural 16-state TAP model.
module tb_jtag_scan_sequencer;
   logic       tclk;
   logic       trst;
   logic       tms, tdi, tdo, busy;
   logic [3:0] tap_state;

   jtag_scan_sequencer_if #(.MAX_LEN(32)) bus ();

   jtag_scan_sequencer #(.MAX_LEN(32)) dut (
      .tclk_i      (tclk),
      .trst_i      (trst),
      .bus_io      (bus),
      .tms_o       (tms),
      .tdi_o       (tdi),
      .tdo_i       (tdo),
      .busy_o      (busy),
      .tap_state_o (tap_state)
   );

   int          n_chk = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   bit          mon_en = 1'b0;
   int          acc_q[$];
   int          rsp_cyc_q[$];
   logic [31:0] rsp_dat_q[$];
   logic        tdi_q[$];
   logic        tms_hist [0:4095];

   // TAP model
   logic [3:0]  m_state;
   logic [31:0] dr_sr, ir_sr, dr_pre, ir_pre;

   initial tclk = 1'b0;
   always #5 tclk = ~tclk;
   always @(posedge tclk) cyc <= cyc + 1;

   function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
      case (s)
         4'd0:  return m ? 4'd0  : 4'd1;
         4'd1:  return m ? 4'd2  : 4'd1;
         4'd2:  return m ? 4'd9  : 4'd3;
         4'd3:  return m ? 4'd5  : 4'd4;
         4'd4:  return m ? 4'd5  : 4'd4;
         4'd5:  return m ? 4'd8  : 4'd6;
         4'd6:  return m ? 4'd7  : 4'd6;
         4'd7:  return m ? 4'd8  : 4'd4;
         4'd8:  return m ? 4'd2  : 4'd1;
         4'd9:  return m ? 4'd0  : 4'd10;
         4'd10: return m ? 4'd12 : 4'd11;
         4'd11: return m ? 4'd12 : 4'd11;
         4'd12: return m ? 4'd15 : 4'd13;
         4'd13: return m ? 4'd14 : 4'd13;
         4'd14: return m ? 4'd15 : 4'd11;
         default: return m ? 4'd2 : 4'd1;
      endcase
   endfunction

   always @(posedge tclk or posedge trst) begin
      if (trst) begin
         m_state <= 4'd0;
         dr_sr   <= '0;
         ir_sr   <= '0;
      end else begin
         case (m_state)
            4'd3:  dr_sr <= dr_pre;
            4'd4:  dr_sr <= {tdi, dr_sr[31:1]};
            4'd10: ir_sr <= ir_pre;
            4'd11: ir_sr <= {tdi, ir_sr[31:1]};
            default: ;
         endcase
         m_state <= tap_next(m_state, tms);
      end
   end

   assign tdo = (m_state == 4'd4) ? dr_sr[0] : (m_state == 4'd11) ? ir_sr[0] : 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(negedge tclk) begin
      tms_hist[cyc[11:0]] = tms;
      if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc + 1);
      if (bus.rsp_valid) begin
         rsp_cyc_q.push_back(cyc);
         rsp_dat_q.push_back(bus.rsp_data);
      end
      if (m_state == 4'd4 || m_state == 4'd11) tdi_q.push_back(tdi);
      if (mon_en) begin
         check_eq("tap_state", 64'(tap_state), 64'(m_state));
         if (m_state != 4'd4 && m_state != 4'd11) check_eq("tdi_idle", 64'(tdi), 64'(0));
      end
   end

   task automatic check_in_reset(input string tag);
      check_eq({tag, "_tms"}, 64'(tms), 64'(1));
      check_eq({tag, "_tdi"}, 64'(tdi), 64'(0));
      check_eq({tag, "_ready"}, 64'(bus.cmd_ready), 64'(0));
      check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
      check_eq({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
      check_eq({tag, "_busy"}, 64'(busy), 64'(1));
      check_eq({tag, "_tap"}, 64'(tap_state), 64'(0));
   endtask

   // Called just after the edge where TRST falls or the reset sequence is entered.
   task automatic check_reset_seq(input string tag);
      logic [5:0] seq;
      for (int i = 0; i < 6; i++) begin
         @(negedge tclk);
         seq[i] = tms;
      end
      check_eq({tag, "_tms_seq"}, 64'(seq), 64'(6'b011111));
      @(negedge tclk);
      check_eq({tag, "_ready"}, 64'(bus.cmd_ready), 64'(1));
      check_eq({tag, "_tap_rti"}, 64'(tap_state), 64'(1));
      check_eq({tag, "_busy"}, 64'(busy), 64'(0));
      check_eq({tag, "_model_rti"}, 64'(m_state), 64'(1));
   endtask

   task automatic wait_acc(input string tag, input int base);
      for (int i = 0; i < 40 && acc_q.size() <= base; i++) @(negedge tclk);
      check_eq({tag, "_accepted"}, 64'(acc_q.size()), 64'(base + 1));
   endtask

   task automatic send_cmd(input logic is_ir, input logic [5:0] len, input logic [31:0] data,
                           input string tag, output int acc_idx);
      acc_idx = acc_q.size();
      tdi_q.delete();
      @(posedge tclk);
      #1;
      bus.cmd_is_ir = is_ir;
      bus.cmd_len   = len;
      bus.cmd_data  = data;
      bus.cmd_valid = 1'b1;
      wait_acc(tag, acc_idx);
      @(posedge tclk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic await_rsp(input string tag, input int acc_idx, input int rsp_idx,
                            input int exp_lat, input logic [31:0] exp_rsp, input string exp_tms,
                            input int exp_nbits, input logic [63:0] exp_tdi);
      logic [63:0] obs_v, exp_v;
      int a, r;
      for (int i = 0; i < 150 && rsp_cyc_q.size() <= rsp_idx; i++) @(negedge tclk);
      check_eq({tag, "_rsp_seen"}, 64'(rsp_cyc_q.size() > rsp_idx), 64'(1));
      if (rsp_cyc_q.size() > rsp_idx && acc_q.size() > acc_idx) begin
         a = acc_q[acc_idx];
         r = rsp_cyc_q[rsp_idx];
         check_eq({tag, "_latency"}, 64'(r - a), 64'(exp_lat));
         check_eq({tag, "_rsp_data"}, 64'(rsp_dat_q[rsp_idx]), 64'(exp_rsp));
         obs_v = '0;
         exp_v = '0;
         for (int j = 0; j < exp_tms.len() && j < 64; j++) begin
            obs_v[j] = tms_hist[12'(a + j)];
            exp_v[j] = (exp_tms[j] == "1");
         end
         check_eq({tag, "_tms_seq"}, obs_v, exp_v);
      end
      if (exp_nbits >= 0) begin
         check_eq({tag, "_tdi_count"}, 64'(tdi_q.size()), 64'(exp_nbits));
         obs_v = '0;
         for (int j = 0; j < tdi_q.size() && j < 64; j++) obs_v[j] = tdi_q[j];
         check_eq({tag, "_tdi_bits"}, obs_v, exp_tdi);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int    ai, ab, rb, tlr_edge;
      string s32;
      trst          = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_is_ir = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      bus.cmd_tlr   = 1'b0;
      dr_pre        = '0;
      ir_pre        = '0;
      s32 = "100";
      repeat (31) s32 = {s32, "0"};
      s32 = {s32, "110"};

      // Power-on reset
      #3 trst = 1'b1;
      #1 mon_en = 1'b1;
      repeat (3) @(negedge tclk);
      check_in_reset("por");
      @(posedge tclk);
      #1 trst = 1'b0;
      check_reset_seq("por");

      // DR scan, 8 bits
      dr_pre = 32'hDEAD_BE3C;
      rb = rsp_cyc_q.size();
      send_cmd(1'b0, 6'd8, 32'h0000_00A5, "dr8", ai);
      await_rsp("dr8", ai, rb, 13, 32'h3C, "1000000000110", 8, 64'hA5);

      // IR scan, 4 bits
      ir_pre = 32'hFFFF_FFF1;
      rb = rsp_cyc_q.size();
      send_cmd(1'b1, 6'd4, 32'h0000_000E, "ir4", ai);
      await_rsp("ir4", ai, rb, 10, 32'h1, "1100000110", 4, 64'hE);
      repeat (3) @(negedge tclk);
      check_eq("ir4_rsp_hold", 64'(bus.rsp_data), 64'h1);
      check_eq("ir4_rsp_pulse", 64'(bus.rsp_valid), 64'(0));

      // Back-to-back DR 1 then DR 32 with cmd_valid held
      dr_pre = 32'h1234_5679;
      rb = rsp_cyc_q.size();
      ab = acc_q.size();
      tdi_q.delete();
      @(posedge tclk);
      #1;
      bus.cmd_is_ir = 1'b0;
      bus.cmd_len   = 6'd1;
      bus.cmd_data  = 32'h0;
      bus.cmd_valid = 1'b1;
      wait_acc("b2b1", ab);
      @(posedge tclk);
      #1;
      bus.cmd_len  = 6'd32;
      bus.cmd_data = 32'hFFFF_FFFF;
      wait_acc("b2b2", ab + 1);
      @(posedge tclk);
      #1;
      bus.cmd_valid = 1'b0;
      await_rsp("b2b1", ab, rb, 6, 32'h1, "100110", -1, 64'h0);
      if (acc_q.size() > ab + 1 && rsp_cyc_q.size() > rb)
         check_eq("b2b_accept_in_rsp_cycle", 64'(acc_q[ab + 1]), 64'(rsp_cyc_q[rb] + 1));
      await_rsp("b2b2", ab + 1, rb + 1, 37, 32'h1234_5679, s32, -1, 64'h0);
      check_eq("b2b_tdi_count", 64'(tdi_q.size()), 64'(33));
      begin
         logic [63:0] v;
         v = '0;
         for (int j = 0; j < tdi_q.size() && j < 64; j++) v[j] = tdi_q[j];
         check_eq("b2b_tdi_bits", v, 64'h1_FFFF_FFFE);
      end

      // Oversize length clamps to 32
      dr_pre = 32'hCAFE_F00D;
      rb = rsp_cyc_q.size();
      send_cmd(1'b0, 6'd40, 32'h0F0F_1234, "clamp", ai);
      await_rsp("clamp", ai, rb, 37, 32'hCAFE_F00D, s32, 32, 64'h0F0F_1234);

      // TRST in the middle of a 16-bit DR shift
      rb = rsp_cyc_q.size();
      send_cmd(1'b0, 6'd16, 32'h0000_BEEF, "abort", ai);
      for (int i = 0; i < 20 && m_state != 4'd4; i++) @(negedge tclk);
      check_eq("abort_in_shift", 64'(tap_state), 64'(4));
      repeat (5) @(negedge tclk);
      #2 trst = 1'b1;
      #1;
      check_in_reset("abort");
      @(posedge tclk);
      @(posedge tclk);
      #1 trst = 1'b0;
      check_reset_seq("abort");
      repeat (20) @(negedge tclk);
      check_eq("abort_no_rsp", 64'(rsp_cyc_q.size()), 64'(rb));
      check_eq("abort_rsp_cleared", 64'(bus.rsp_data), 64'(0));

      // cmd_tlr with cmd_valid: reset sequence first, then a len=0 command acts as len=1
      mon_en = 1'b0;
      dr_pre = 32'h0000_0003;
      rb = rsp_cyc_q.size();
      ab = acc_q.size();
      tdi_q.delete();
      @(posedge tclk);
      #1;
      bus.cmd_tlr   = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_is_ir = 1'b0;
      bus.cmd_len   = 6'd0;
      bus.cmd_data  = 32'h0000_0001;
      @(negedge tclk);
      check_eq("tlr_ready_masked", 64'(bus.cmd_ready), 64'(0));
      @(posedge tclk);
      #1;
      bus.cmd_tlr = 1'b0;
      tlr_edge    = cyc;
      check_reset_seq("tlr");
      @(posedge tclk);
      #1;
      bus.cmd_valid = 1'b0;
      mon_en        = 1'b1;
      check_eq("tlr_accept_count", 64'(acc_q.size()), 64'(ab + 1));
      if (acc_q.size() > ab) check_eq("tlr_accept_edge", 64'(acc_q[ab]), 64'(tlr_edge + 7));
      await_rsp("len0", ab, rb, 6, 32'h1, "100110", 1, 64'h1);

      repeat (4) @(negedge tclk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/jtag_scan_sequencer.md
Name: jtag_scan_sequencer

Overview:
- Master-side controller that drives TMS/TDI into the team's 16-state JTAG TAP controller and collects TDO.
- Turns one command (IR or DR scan, length N, data) into the exact TMS sequence, shifts data LSB first and returns the captured TDO bits through a valid/ready handshake.
- Sits between the host/debug logic and the TAP. Both run on the same TCLK, so the sequencer's state advances in lockstep with the TAP state.

Parameters:
- MAX_LEN, 32, maximum scan length in bits.
- LEN_W, $clog2(MAX_LEN+1), width of cmd_len.

Ports:
- TCLK  input  1  scan clock; all state changes on its rising edge.
- TRST  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted on the edge where cmd_valid && cmd_ready.
- cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
- cmd_len  input  LEN_W  scan length in bits, 1..MAX_LEN.
- cmd_data  input  MAX_LEN  bits to shift in; bit 0 is shifted first.
- cmd_tlr  input  1  in IDLE, request a TAP reset sequence; takes priority over cmd_valid.
- rsp_valid  output  1  one-cycle pulse; rsp_data is valid in that cycle.
- rsp_data  output  MAX_LEN  captured TDO bits; bit i is the i-th shifted bit; bits >= len are 0.
- tms  output  1  TMS to the TAP; Moore decode of the sequencer state.
- tdi  output  1  TDI to the TAP.
- tdo  input  1  TDO from the TAP.
- busy  output  1  high when state != IDLE.
- tap_state  output  4  mirrored TAP state, TAP encoding (TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, UpdIR=15).

Behaviour:
- Reset values (TRST high):
  - state = RST_SEQ, counter = 0.
  - tms = 1, tdi = 0, cmd_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 1, tap_state = 0.
- States, with tms value / mirrored tap_state / next state:
  - RST_SEQ: tms 1 / tap_state 0 / stays for 5 cycles (counter 0..4), then TLR.
  - TLR: tms 0 / 0 / IDLE.
  - IDLE: tms 0 / 1 / cmd_ready = 1. cmd_tlr -> RST_SEQ; accepted command -> LAUNCH. The command (is_ir, len, data) is latched; len = 0 is treated as 1. rx is cleared.
  - LAUNCH: tms 1 / 1 / SEL_DR.
  - SEL_DR: tms = is_ir / 2 / SEL_IR if IR, else CAPTURE.
  - SEL_IR: tms 0 / 9 / CAPTURE.
  - CAPTURE: tms 0 / 3 or 10 / SHIFT, with bit index = 0.
  - SHIFT: tms = (idx == len-1); tdi = data[idx]. On each edge rx[idx] <= tdo and idx++. After the last bit -> EXIT1. tap_state 4 or 11.
  - EXIT1: tms 1 / 5 or 12 / UPDATE.
  - UPDATE: tms 0 / 8 or 15 / IDLE. rsp_valid is registered high for the first IDLE cycle, with rsp_data = rx.
- tdi = 0 in every state except SHIFT.
- Pause and Exit2 states are never entered.
- Latency from accept edge to the rsp_valid cycle: DR = N+5 cycles, IR = N+6 cycles.
- cmd_ready is high in the rsp_valid cycle, so back-to-back commands are legal.
- rsp_valid does not wait for a ready; the consumer must take it.
- rsp_data holds its value until the next response.
- cmd_* inputs are ignored outside IDLE. cmd_valid and cmd_tlr together in IDLE: the reset wins and the command stays pending.
- TRST asserted mid-scan: immediate return to RST_SEQ. No rsp_valid is issued for the aborted command. After TRST falls, 5 cycles of tms = 1 and one TLR cycle, then IDLE.
- cmd_len > MAX_LEN is clamped to MAX_LEN.

Test Plan:
- TRST pulse then release -> tms = 1 for 5 cycles, 0 for 1, then cmd_ready = 1 and tap_state = 1. Checked against a TAP model whose state reaches RTI.
- DR scan, len = 8, data = 0xA5, TAP model DR preloaded 0x3C -> tms sequence 1,0,0,0000000 1,1,0; tdi bits 1,0,1,0,0,1,0,1; rsp_valid 13 cycles after accept with rsp_data = 0x3C.
- IR scan, len = 4, data = 0xE, TAP returns 0x1 -> tms 1,1,0,0,0001,1,0; rsp_valid 10 cycles after accept with rsp_data = 0x1. tap_state matches the model every cycle.
- Back-to-back DR len = 1 then DR len = MAX_LEN = 32 with data 0xFFFFFFFF, with cmd_valid held -> second command accepted in the rsp_valid cycle of the first; second response arrives 37 cycles after that accept.
- TRST asserted during SHIFT of a 16-bit scan -> tms = 1 immediately, no rsp_valid; the full reset sequence completes after release.
- cmd_tlr and cmd_valid together in IDLE -> reset sequence runs first, then the command is accepted. cmd_len = 0 -> behaves as len = 1.
